// File: rtl/layer_mac_array.sv
// layer_mac_array: LANES-wide signed-weight x unsigned-input MAC over NUM_INPUTS elements plus bias.
// Define LAYER_MAC_RELU_EN to clamp negative results to zero in the output stage.
module layer_mac_array #(
  parameter int WEIGHTS_WIDTH = 8,
  parameter int BIAS_WIDTH    = 32,
  parameter int LANES         = 4,
  parameter int NUM_INPUTS    = 784
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           IN_VALID,
  output logic                           IN_READY,
  input  logic [LANES*WEIGHTS_WIDTH-1:0] WEIGHTS,
  input  logic [LANES*WEIGHTS_WIDTH-1:0] INPUTS,
  input  logic [BIAS_WIDTH-1:0]          BIAS,
  output logic                           OUT_VALID,
  input  logic                           OUT_READY,
  output logic [BIAS_WIDTH-1:0]          RESULT,
  output logic                           BUSY
);
  localparam int WW    = WEIGHTS_WIDTH;
  localparam int PW    = 2*WW + 1;
  localparam int BEATS = NUM_INPUTS / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {ACCUM, DRAIN, OUTPUT} state_t;

  state_t                 state;
  logic [CW-1:0]          beat_cnt;
  logic                   accept, first_beat, last_beat;
  logic signed [PW-1:0]   prod_d [LANES];
  logic signed [PW-1:0]   prod_q [LANES];
  logic                   p_valid, p_first, p_last;
  logic [BIAS_WIDTH-1:0]  lane_sum, s_sum;
  logic                   s_valid, s_first, s_last;
  logic [BIAS_WIDTH-1:0]  acc, bias_q, final_sum, final_val;
  logic                   acc_done;

  assign accept     = IN_VALID && IN_READY;
  assign first_beat = (beat_cnt == '0);
  assign last_beat  = (beat_cnt == LAST_BEAT);

  always_comb begin
    logic signed [PW-1:0] w_ext;
    logic signed [PW-1:0] x_ext;
    prod_d = '{default: '0};
    w_ext  = '0;
    x_ext  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      w_ext     = PW'($signed(WEIGHTS[i*WW +: WW]));
      x_ext     = PW'({1'b0, INPUTS[i*WW +: WW]});
      prod_d[i] = w_ext * x_ext;
    end
  end

  // Products sign-extend into the accumulator width; all sums wrap.
  always_comb begin
    lane_sum = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + BIAS_WIDTH'(prod_q[i]);
    end
  end

  assign final_sum = acc + bias_q;

`ifdef LAYER_MAC_RELU_EN
  assign final_val = final_sum[BIAS_WIDTH-1] ? '0 : final_sum;
`else
  assign final_val = final_sum;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned i = 0; i < LANES; i++) prod_q[i] <= '0;
      p_valid  <= 1'b0;
      p_first  <= 1'b0;
      p_last   <= 1'b0;
      s_sum    <= '0;
      s_valid  <= 1'b0;
      s_first  <= 1'b0;
      s_last   <= 1'b0;
      acc      <= '0;
      acc_done <= 1'b0;
      bias_q   <= '0;
    end else begin
      p_valid <= accept;
      if (accept) begin
        prod_q  <= prod_d;
        p_first <= first_beat;
        p_last  <= last_beat;
        if (first_beat) bias_q <= BIAS;
      end
      s_valid <= p_valid;
      if (p_valid) begin
        s_sum   <= lane_sum;
        s_first <= p_first;
        s_last  <= p_last;
      end
      acc_done <= s_valid && s_last;
      // First lane sum of a vector overwrites ACC rather than adding to stale data.
      if (s_valid) acc <= s_first ? s_sum : acc + s_sum;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ACCUM;
      beat_cnt  <= '0;
      IN_READY  <= 1'b0;
      OUT_VALID <= 1'b0;
      RESULT    <= '0;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          IN_READY <= 1'b1;
          if (accept) begin
            if (first_beat) BUSY <= 1'b1;
            if (last_beat) begin
              beat_cnt <= '0;
              IN_READY <= 1'b0;
              state    <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (acc_done) begin
            RESULT    <= final_val;
            OUT_VALID <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            BUSY      <= 1'b0;
            IN_READY  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_layer_mac_array.sv
// Bench for layer_mac_array (LANES=4, NUM_INPUTS=8): scoreboard of expected results
// plus directed timing, backpressure, wrap and reset checks.
module tb_layer_mac_array;
  localparam int WW = 8;
  localparam int BW = 32;
  localparam int LN = 4;
  localparam int NI = 8;
  localparam int BEATS = NI / LN;

  logic          clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [LN*WW-1:0] weights, inputs;
  logic [BW-1:0] bias, result;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [BW-1:0] sb [$];
  int w_arr [NI];
  int x_arr [NI];

  layer_mac_array #(
    .WEIGHTS_WIDTH(WW),
    .BIAS_WIDTH(BW),
    .LANES(LN),
    .NUM_INPUTS(NI)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .IN_VALID(in_valid),
    .IN_READY(in_ready),
    .WEIGHTS(weights),
    .INPUTS(inputs),
    .BIAS(bias),
    .OUT_VALID(out_valid),
    .OUT_READY(out_ready),
    .RESULT(result),
    .BUSY(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] model(input logic [BW-1:0] b);
    logic [BW-1:0] s;
    s = b;
    for (int k = 0; k < NI; k++) s = s + BW'(w_arr[k] * x_arr[k]);
`ifdef LAYER_MAC_RELU_EN
    if (s[BW-1]) s = '0;
`endif
    return s;
  endfunction

  // Scoreboard: compare every output handshake against the oldest expected result.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("unexpected_output", 1, 0);
        else check("result", result, sb.pop_front());
      end
    end
  end

  task automatic drive_beat(input int b);
    int   waited;
    logic ok;
    in_valid = 1'b1;
    for (int l = 0; l < LN; l++) begin
      weights[l*WW +: WW] = 8'(w_arr[b*LN + l]);
      inputs[l*WW +: WW]  = 8'(x_arr[b*LN + l]);
    end
    ok = 1'b0;
    waited = 0;
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    check("beat_accept", ok, 1);
  endtask

  task automatic send_vector(input logic [BW-1:0] b, input int gap);
    sb.push_back(model(b));
    bias = b;
    for (int bt = 0; bt < BEATS; bt++) begin
      drive_beat(bt);
      bias = $urandom;
      if (bt < BEATS - 1) begin
        for (int g = 0; g < gap; g++) begin
          check("busy_gap", busy, 1);
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic wait_output();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("out_handshake", done, 1);
  endtask

  task automatic set_basic();
    for (int k = 0; k < NI; k++) begin
      w_arr[k] = k + 1;
      x_arr[k] = 1;
    end
  endtask

  initial begin
    logic [BW-1:0] bp_exp;
    logic seen;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    weights = '0;
    inputs = '0;
    bias = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("in_ready_pre_edge", in_ready, 0);
    @(posedge clk);
    #1;
    check("in_ready_rise", in_ready, 1);

    // Basic dot product with exact latency checks
    set_basic();
    check("model_basic", model(32'd10), 32'd46);
    send_vector(32'd10, 0);
    check("lat_ready_drop", in_ready, 0);
    check("lat_busy", busy, 1);
    check("lat_ov_n0", out_valid, 0);
    @(posedge clk); #1;
    check("lat_ov_n1", out_valid, 0);
    @(posedge clk); #1;
    check("lat_ov_n2", out_valid, 0);
    @(posedge clk); #1;
    check("lat_ov_n3", out_valid, 1);
    check("lat_ready_n3", in_ready, 0);
    @(posedge clk); #1;
    check("lat_ov_n4", out_valid, 0);
    check("lat_ready_n4", in_ready, 1);
    check("lat_busy_n4", busy, 0);

    // Signed extremes
    for (int k = 0; k < NI; k++) begin
      w_arr[k] = -128;
      x_arr[k] = 255;
    end
    send_vector(32'd0, 0);
    wait_output();

    // Bubbles: IN_VALID pattern 1,0,0,1
    set_basic();
    send_vector(32'd10, 2);
    wait_output();

    // Backpressure
    out_ready = 1'b0;
    set_basic();
    bp_exp = model(32'd10);
    send_vector(32'd10, 0);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_out_valid_seen", seen, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_result", result, bp_exp);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // Wrap: bias max positive plus one
    for (int k = 0; k < NI; k++) begin
      w_arr[k] = 0;
      x_arr[k] = 0;
    end
    w_arr[0] = 1;
    x_arr[0] = 1;
`ifndef LAYER_MAC_RELU_EN
    check("model_wrap", model(32'h7FFF_FFFF), 32'h8000_0000);
`endif
    send_vector(32'h7FFF_FFFF, 0);
    wait_output();

    // Reset mid-vector
    for (int k = 0; k < NI; k++) begin
      w_arr[k] = 100;
      x_arr[k] = 200;
    end
    bias = 32'd5;
    drive_beat(0);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    set_basic();
    send_vector(32'd10, 0);
    wait_output();

    // Random vectors with random bubbles
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < NI; k++) begin
        w_arr[k] = int'($urandom_range(255, 0)) - 128;
        x_arr[k] = int'($urandom_range(255, 0));
      end
      send_vector($urandom, int'($urandom_range(2, 0)));
      wait_output();
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/layer_mac_array.md
# layer_mac_array

Parametrised multi-lane multiply-accumulate engine that computes one neuron of a fully connected layer. Each cycle it consumes `LANES` weight/input pairs, forms their products, reduces them through a registered adder tree, accumulates over `NUM_INPUTS` elements, adds a bias, and presents one signed result per vector. It sits between the weight/activation fetch logic and the layer output buffer, and adds width, lane count, pipelining and flow control to the single-product multiply stage.

## Interface
- `WEIGHTS_WIDTH`, default 8: bit-width of each weight and each input element.
- `BIAS_WIDTH`, default 32: width of the bias, the accumulator and `RESULT`.
- `LANES`, default 4: number of products formed per beat. Must be ≥1.
- `NUM_INPUTS`, default 784: elements per vector. Must be a multiple of `LANES`. `BEATS = NUM_INPUTS/LANES`.
- `CLK`, in, 1: the only clock, rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `IN_VALID`, in, 1: the beat on `WEIGHTS`/`INPUTS` is valid.
- `IN_READY`, out, 1: the block accepts a beat. Registered.
- `WEIGHTS`, in, `LANES*WEIGHTS_WIDTH`: lane i is at `[i*WW +: WW]`, signed two's complement.
- `INPUTS`, in, `LANES*WEIGHTS_WIDTH`: lane i is at the same slice, unsigned.
- `BIAS`, in, `BIAS_WIDTH`: signed. Sampled on beat 0 of a vector only.
- `OUT_VALID`, out, 1: `RESULT` is valid.
- `OUT_READY`, in, 1: the downstream block accepts `RESULT`.
- `RESULT`, out, `BIAS_WIDTH`: signed dot product plus bias.
- `BUSY`, out, 1: high from the beat-0 handshake until the output handshake.

## Operation
- A beat is accepted when `IN_VALID && IN_READY` at a rising edge. The beat counter counts 0..`BEATS-1`.
- **FSM states:**
  - `ACCUM`: `IN_READY`=1. The state is `ACCUM` with the counter at 0 when idle. On the last beat the FSM goes to `DRAIN`.
  - `DRAIN`: `IN_READY`=0. Waits for the pipeline to empty, then goes to `OUTPUT`.
  - `OUTPUT`: `OUT_VALID`=1. On `OUT_READY` the FSM goes to `ACCUM` with the counter at 0.
- **Arithmetic:**
  - Each lane computes signed(weight) × zero-extended(input) with a `2*WW+1`-bit signed result.
  - Products are sign-extended to `BIAS_WIDTH` before summing.
  - The accumulator and the bias add wrap modulo 2^`BIAS_WIDTH`. There is no saturation.
- **Pipeline:** P (products register) → S (lane-sum register) → ACC (accumulator). Each stage carries its own valid bit, so `IN_VALID` bubbles do not change the result.
- ACC clears on the beat-0 handshake: the first lane sum loads into ACC instead of being added to it.
- `RESULT` holds stable while `OUT_VALID && !OUT_READY`.
- **Reset mid-vector:** discards all partial state. The next beat is treated as beat 0.

## Timing
- **Reset values:** `IN_READY`=0, `OUT_VALID`=0, `RESULT`=0, `BUSY`=0, counter 0, all pipeline valids 0.
- `IN_READY` rises at the first rising edge after `RST` is deasserted.
- **Latency:** for a last beat accepted at edge n, P is loaded at n, S at n+1, ACC at n+2, and `RESULT`/`OUT_VALID` are registered at n+3. `OUT_VALID` is therefore high in the cycle after edge n+3.
- `IN_READY` drops in the cycle after the last-beat edge.
- After an output handshake at edge m, `IN_READY` is 1 in the cycle after m. The next vector's beat 0 can be accepted at edge m+1.
- **Minimum period per vector:** `BEATS`+4 cycles with `OUT_READY` held high.
- When `BEATS`=1, beat 0 is also the last beat: it loads ACC and then goes straight to `DRAIN`.

## Configuration
- `LAYER_MAC_RELU_EN`:
  - **Defined:** the final stage clamps negative `RESULT` values to 0 before registering them, as a fused ReLU. Latency is unchanged.
  - **Undefined:** `RESULT` is the raw wrapped signed sum.

## Test plan
- **Basic dot product** (LANES=4, NUM_INPUTS=8): inputs all 1, weights 1..8, bias 10, `OUT_READY`=1 → `RESULT`=46. `OUT_VALID` is high 3 cycles after the second beat edge, for one cycle.
- **Signed extremes:** weights all −128, inputs all 255, bias 0 → `RESULT`=−261120. With `LAYER_MAC_RELU_EN` defined → `RESULT`=0.
- **Bubbles:** the same vector as the first test with `IN_VALID` toggled 1,0,0,1 → `RESULT`=46. `BUSY` stays high across the gap.
- **Backpressure:** hold `OUT_READY`=0 for 5 cycles → `RESULT` and `OUT_VALID` stay stable and `IN_READY`=0. Then raise `OUT_READY` → handshake, and `IN_READY`=1 in the next cycle.
- **Wrap:** bias 0x7FFFFFFF, a single product of +1 with the rest 0 → `RESULT`=0x80000000 when the macro is undefined.
- **Reset mid-vector:** assert `RST` after beat 0 → all outputs go to reset values immediately. The next full vector from the first test gives exactly 46.
